gen_tx_fifo: RTL and testbench
==============================

// Module: gen_tx_fifo
// PURPOSE
//  Write-side traffic generator for the PCS25G TX FIFO; the producer matching the TX FIFO read-side checker.
//  Emits 24-bit beats of two 12-bit slots: a SYNC preamble, then LANEOK markers, then a payload of 12-bit words.
//  Payload words increment by 8 modulo 4096. Slots not carrying payload are filled with IDLE.
//  Sits in the pcs25g testbench/BIST path, driving the TX FIFO write port under FIFO backpressure.
// PARAMETERS
//  START_VAL     12'h000  value of first payload word
//  SYNC_BEATS    4        preamble beats, en_wr=00, both slots SYNC
//  LANEOK_BEATS  2        marker beats, en_wr=00, both slots {LANEOK_HEAD, LANE_ID}
//  LANE_ID       8'h00    low byte of LANEOK marker
//  LFSR_SEED     16'hACE1 nonzero seed for slot-enable pattern
// PORTS
//  clk        in   1   clock
//  reset_n    in   1   asynchronous active-low reset
//  start      in   1   pulse: begin a frame (ignored while busy)
//  num_words  in   16  payload word count, latched on accepted start; 0 = no payload
//  full       in   1   TX FIFO full; beat not accepted while high
//  push       out  1   beat valid
//  en_wr      out  2   slot valid: [0]=data_wr[11:0], [1]=data_wr[23:12]
//  data_wr    out  24  beat data
//  busy       out  1   frame in progress
//  done       out  1   one-cycle pulse after last payload beat accepted
//  inj_err    in   1   (GEN_TX_FIFO_ERRINJ_EN only) corrupt next payload word
// BEHAVIOUR
//  Constants: IDLE=12'h555, SYNC=12'hAAA, LANEOK_HEAD=4'hB.
//  Reset: push=0, en_wr=0, data_wr=0, busy=0, done=0; state=S_IDLE; next_val=START_VAL; lfsr=LFSR_SEED.
//  All outputs registered. Beat accepted on a clk edge with push=1 & full=0.
//  While full=1, push/en_wr/data_wr hold stable. The next beat is presented the cycle after acceptance.
//  FSM: S_IDLE -start-> S_SYNC (SYNC_BEATS accepted) -> S_LANEOK (LANEOK_BEATS accepted) -> S_RUN -> S_DONE -> S_IDLE.
//  Any phase with a zero beat count is skipped. S_RUN is skipped when num_words=0.
//  S_RUN: en_wr = lfsr[1:0], Fibonacci x^16+x^14+x^13+x^11+1, advanced once per accepted beat.
//  If words_left=1 and en_wr=11, en_wr becomes 01.
//  Slot order within a beat: en=01 -> low=v; en=10 -> high=v; en=11 -> low=v, high=v+8.
//  Non-enabled slot = IDLE. en=00 beats carry IDLE/IDLE and do not consume words.
//  next_val advances +8 per payload word, 12-bit wrap (12'hFF8 -> 12'h000). words_left decrements by popcount(en_wr).
//  next_val persists across frames; only reset restores START_VAL.
//  S_DONE: push=0; done=1 for one cycle; busy falls with done.
//  start while busy: ignored.
//  Reset mid-frame: immediate return to reset values; no partial beat held.
// CONFIGURATION
//  `GEN_TX_FIFO_ERRINJ_EN defined:
//   - inj_err pulse arms a flag.
//   - The next payload word emitted (lowest-enabled slot) has bit 0 inverted.
//   - next_val sequencing is unaffected; the flag clears on acceptance.
//  Undefined: inj_err port absent; no corruption logic.
// STRUCTURE
//  Package pcs25g_tx_pkg: IDLE, SYNC, LANEOK_HEAD, state enum, LFSR taps; shared with the read-side checker.
//  One sub-module: gen_tx_fifo_lfsr (16-bit, seed, advance enable). FSM and counters stay inline.
// TESTING
//  - Reset, then start, num_words=0, full=0 -> 4 SYNC beats (24'hAAAAAA), 2 LANEOK beats (24'hB00B00), done; no en_wr!=0.
//  - num_words=20, full=0 -> words 0x000,0x008,..,0x098 in order; popcount sum=20; exactly one done pulse.
//  - full held high 5 cycles mid-RUN -> push/en_wr/data_wr stable throughout; no word skipped or repeated.
//  - START_VAL=12'hFF0, num_words=4 -> 0xFF0,0xFF8,0x000,0x008 (wrap).
//  - reset_n low during S_RUN -> outputs 0 asynchronously; restart yields SYNC preamble and START_VAL.
//  - ERRINJ_EN: inj_err during RUN -> one word with bit0 flipped, checker flags once, later words correct.

Source files
------------

// File: rtl/pcs25g_tx_pkg.sv
// Shared PCS25G TX FIFO definitions: slot fill words, LANEOK header, generator states and
// the slot-enable LFSR taps, used by both the write-side generator and the read-side checker.
package pcs25g_tx_pkg;

    localparam logic [11:0] IDLE        = 12'h555;
    localparam logic [11:0] SYNC        = 12'hAAA;
    localparam logic [3:0]  LANEOK_HEAD = 4'hB;
    localparam logic [11:0] WORD_STEP   = 12'h008;

    // Fibonacci x^16+x^14+x^13+x^11+1, right-shifting: taps at bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS   = 16'h002D;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_LANEOK = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } tx_state_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        lfsr_step = {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

    function automatic logic [1:0] popcount2(input logic [1:0] en);
        popcount2 = {1'b0, en[0]} + {1'b0, en[1]};
    endfunction

endpackage

// File: rtl/gen_tx_fifo_lfsr.sv
// 16-bit slot-enable LFSR; exposes the current and the one-step-ahead enable pair.
module gen_tx_fifo_lfsr
    import pcs25g_tx_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       adv,
    output logic [1:0] en_cur,
    output logic [1:0] en_nxt
);

    logic [15:0] lfsr_r;
    logic [15:0] lfsr_nxt_s;

    assign lfsr_nxt_s = lfsr_step(lfsr_r);
    assign en_cur     = lfsr_r[1:0];
    assign en_nxt     = lfsr_nxt_s[1:0];

    // LFSR state, stepped once per accepted payload beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_r <= SEED;
        end else if (adv) begin
            lfsr_r <= lfsr_nxt_s;
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

endmodule

// File: rtl/gen_tx_fifo.sv
// PCS25G TX FIFO write-side traffic generator: SYNC preamble, LANEOK markers, then an LFSR-slotted
// payload of +8 words. Optional error injection is built when GEN_TX_FIFO_ERRINJ_EN is defined.
module gen_tx_fifo
    import pcs25g_tx_pkg::*;
#(
    parameter logic [11:0] START_VAL    = 12'h000,
    parameter logic [15:0] SYNC_BEATS   = 16'd4,
    parameter logic [15:0] LANEOK_BEATS = 16'd2,
    parameter logic [7:0]  LANE_ID      = 8'h00,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] num_words,
    input  logic        full,
`ifdef GEN_TX_FIFO_ERRINJ_EN
    input  logic        inj_err,
`endif
    output logic        push,
    output logic [1:0]  en_wr,
    output logic [23:0] data_wr,
    output logic        busy,
    output logic        done
);

    localparam logic [11:0] LANEOK_WORD = {LANEOK_HEAD, LANE_ID};

    tx_state_e   state_r;
    tx_state_e   tgt_s;
    tx_state_e   after_sync_s;
    tx_state_e   after_laneok_s;
    logic        accept_s;
    logic        load_s;
    logic        adv_s;
    logic        inj_s;
    logic [15:0] cnt_r;
    logic [15:0] words_left_r;
    logic [15:0] words_src_s;
    logic [11:0] next_val_r;
    logic [11:0] lo_s;
    logic [11:0] hi_s;
    logic [1:0]  en_cur_s;
    logic [1:0]  en_nxt_s;
    logic [1:0]  en_raw_s;
    logic [1:0]  en_eff_s;
    logic [1:0]  used_s;

    assign accept_s = push & ~full;

    gen_tx_fifo_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .adv     (adv_s),
        .en_cur  (en_cur_s),
        .en_nxt  (en_nxt_s)
    );

    // Phase skipping: empty phases fall through to the next non-empty one
    always_comb begin
        words_src_s = (state_r == S_IDLE) ? num_words : words_left_r;
        if (words_src_s != 16'd0) begin
            after_laneok_s = S_RUN;
        end else begin
            after_laneok_s = S_DONE;
        end
        if (LANEOK_BEATS != 16'd0) begin
            after_sync_s = S_LANEOK;
        end else begin
            after_sync_s = after_laneok_s;
        end
    end

    // Decide when a new beat or phase must be loaded and where it goes
    always_comb begin
        tgt_s  = state_r;
        load_s = 1'b0;
        adv_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    tgt_s  = (SYNC_BEATS != 16'd0) ? S_SYNC : after_sync_s;
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            S_SYNC: begin
                if (accept_s && (cnt_r == 16'd1)) begin
                    tgt_s  = after_sync_s;
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            S_LANEOK: begin
                if (accept_s && (cnt_r == 16'd1)) begin
                    tgt_s  = after_laneok_s;
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            S_RUN: begin
                if (accept_s) begin
                    adv_s  = 1'b1;
                    tgt_s  = (words_left_r == 16'd0) ? S_DONE : S_RUN;
                    load_s = 1'b1;
                end else begin
                    adv_s  = 1'b0;
                end
            end
            S_DONE: begin
                tgt_s  = S_IDLE;
                load_s = 1'b1;
            end
            default: begin
                tgt_s  = S_IDLE;
                load_s = 1'b1;
            end
        endcase
    end

`ifdef GEN_TX_FIFO_ERRINJ_EN
    logic arm_r;
    logic beat_inj_r;

    // Error arm flag and marker for the presented beat that carries the corrupted word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_r      <= 1'b0;
            beat_inj_r <= 1'b0;
        end else begin
            arm_r <= inj_err | (arm_r & ~(accept_s & beat_inj_r));
            if (load_s) begin
                beat_inj_r <= (tgt_s == S_RUN) & inj_s;
            end else begin
                beat_inj_r <= beat_inj_r;
            end
        end
    end

    assign inj_s = arm_r & ~beat_inj_r & (en_eff_s != 2'b00);
`else
    assign inj_s = 1'b0;
`endif

    // Payload beat formation; a continuing run uses the LFSR value after this acceptance
    always_comb begin
        en_raw_s = adv_s ? en_nxt_s : en_cur_s;
        if ((words_src_s == 16'd1) && (en_raw_s == 2'b11)) begin
            en_eff_s = 2'b01;
        end else begin
            en_eff_s = en_raw_s;
        end
        lo_s = en_eff_s[0] ? next_val_r : IDLE;
        case (en_eff_s)
            2'b10:   hi_s = next_val_r;
            2'b11:   hi_s = next_val_r + WORD_STEP;
            default: hi_s = IDLE;
        endcase
        lo_s   = lo_s ^ {11'd0, inj_s & en_eff_s[0]};
        hi_s   = hi_s ^ {11'd0, inj_s & ~en_eff_s[0]};
        used_s = popcount2(en_eff_s);
    end

    // Main FSM with registered beat outputs; beats hold while full is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            push         <= 1'b0;
            en_wr        <= 2'b00;
            data_wr      <= 24'h000000;
            busy         <= 1'b0;
            done         <= 1'b0;
            cnt_r        <= 16'd0;
            words_left_r <= 16'd0;
            next_val_r   <= START_VAL;
        end else if (load_s) begin
            state_r <= tgt_s;
            case (tgt_s)
                S_SYNC: begin
                    push         <= 1'b1;
                    en_wr        <= 2'b00;
                    data_wr      <= {SYNC, SYNC};
                    busy         <= 1'b1;
                    done         <= 1'b0;
                    cnt_r        <= SYNC_BEATS;
                    words_left_r <= words_src_s;
                end
                S_LANEOK: begin
                    push         <= 1'b1;
                    en_wr        <= 2'b00;
                    data_wr      <= {LANEOK_WORD, LANEOK_WORD};
                    busy         <= 1'b1;
                    done         <= 1'b0;
                    cnt_r        <= LANEOK_BEATS;
                    words_left_r <= words_src_s;
                end
                S_RUN: begin
                    push         <= 1'b1;
                    en_wr        <= en_eff_s;
                    data_wr      <= {hi_s, lo_s};
                    busy         <= 1'b1;
                    done         <= 1'b0;
                    words_left_r <= words_src_s - {14'd0, used_s};
                    next_val_r   <= next_val_r + {7'd0, used_s, 3'd0};
                end
                S_DONE: begin
                    push    <= 1'b0;
                    en_wr   <= 2'b00;
                    data_wr <= 24'h000000;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    push    <= 1'b0;
                    en_wr   <= 2'b00;
                    data_wr <= 24'h000000;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end else if (accept_s && ((state_r == S_SYNC) || (state_r == S_LANEOK))) begin
            cnt_r <= cnt_r - 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_gen_tx_fifo.sv
// Self-checking bench for gen_tx_fifo: a queue-based frame model checked on every accepted beat,
// plus literal expectations for preamble, first payload beat, +8 sequencing, wrap and reset.
module tb_gen_tx_fifo;
    import pcs25g_tx_pkg::*;

    localparam logic [11:0] START = 12'h000;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] num_words;
    logic        full;
    logic        push;
    logic [1:0]  en_wr;
    logic [23:0] data_wr;
    logic        busy;
    logic        done;
`ifdef GEN_TX_FIFO_ERRINJ_EN
    logic        inj_err = 1'b0;
`endif

    gen_tx_fifo #(
        .START_VAL(START), .SYNC_BEATS(16'd4), .LANEOK_BEATS(16'd2),
        .LANE_ID(8'h00), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_words(num_words), .full(full),
`ifdef GEN_TX_FIFO_ERRINJ_EN
        .inj_err(inj_err),
`endif
        .push(push), .en_wr(en_wr), .data_wr(data_wr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          m_beat = 0;
    int          done_cnt = 0;
    logic [15:0] m_lfsr;
    logic [11:0] m_val;
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    logic [23:0] first_beat = 24'h0;
    logic [23:0] first_run = 24'h0;
    bit          chk_en = 1'b0;
    logic        prev_push = 1'b0;
    logic        prev_full = 1'b0;
    logic [1:0]  prev_en = 2'b00;
    logic [23:0] prev_data = 24'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_chk++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    // Model: preamble, markers, then words popped from the expected queue in slot order
    task automatic accept_beat();
        logic [1:0]  e;
        logic [11:0] lo, hi;
        if (m_beat == 0) first_beat = data_wr;
        chk("busy_while_push", busy, 1);
        if (m_beat < 4) begin
            chk("sync_beat", {6'd0, en_wr, data_wr}, {6'd0, 2'b00, 24'hAAAAAA});
        end else if (m_beat < 6) begin
            chk("laneok_beat", {6'd0, en_wr, data_wr}, {6'd0, 2'b00, 24'hB00B00});
        end else if (exp_q.size() == 0) begin
            fail_now("extra_beat", {6'd0, en_wr, data_wr});
        end else begin
            e = m_lfsr[1:0];
            if (exp_q.size() == 1 && e == 2'b11) e = 2'b01;
            lo = IDLE;
            hi = IDLE;
            if (e[0]) lo = exp_q.pop_front();
            if (e[1]) hi = exp_q.pop_front();
            if (m_beat == 6) first_run = data_wr;
            chk("run_beat", {6'd0, en_wr, data_wr}, {6'd0, e, hi, lo});
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
        if (en_wr[0]) got_q.push_back(data_wr[11:0]);
        if (en_wr[1]) got_q.push_back(data_wr[23:12]);
        m_beat++;
    endtask

    // Compare process, sampled on the inactive edge
    always @(negedge clk) begin
        if (chk_en) begin
            if (prev_push && prev_full)
                chk("stall_hold", {5'd0, push, en_wr, data_wr}, {5'd0, prev_push, prev_en, prev_data});
            if (push && !full) accept_beat();
            if (done) begin
                chk("done_all_words", exp_q.size(), 0);
                chk("done_busy_low", {push, busy}, 2'b00);
                done_cnt++;
            end
        end
        prev_push = push;
        prev_full = full;
        prev_en   = en_wr;
        prev_data = data_wr;
    end

    task automatic launch(input int n);
        @(posedge clk);
        #1;
        m_beat = 0;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(m_val);
            m_val = m_val + 12'h008;
        end
        start = 1'b1;
        num_words = 16'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        int t = 0;
        while (done_cnt == d0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk({name, "_done_seen"}, done_cnt != d0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_one_done"}, done_cnt - d0, 1);
        chk({name, "_idle_busy"}, busy, 0);
    endtask

    task automatic wait_words(input int target);
        int t = 0;
        while (got_q.size() < target && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (got_q.size() < target) fail_now("wait_words_timeout", got_q.size());
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_push"}, push, 0);
        chk({name, "_en_wr"}, en_wr, 0);
        chk({name, "_data_wr"}, data_wr, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
    endtask

    initial begin
        int base;
        clk = 1'b0;
        reset_n = 1'b0;
        start = 1'b0;
        num_words = 16'd0;
        full = 1'b0;
        m_val = START;
        m_lfsr = SEED;
        #12;
        chk_outputs_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        chk_en = 1'b1;

        // Frame with no payload: preamble and markers only
        launch(0);
        wait_done("frame0");
        chk("frame0_first_beat", first_beat, 24'hAAAAAA);

        // 20 words with a 5-cycle stall and an ignored start mid-frame
        launch(20);
        wait_words(6);
        @(posedge clk);
        #1 full = 1'b1;
        repeat (5) @(posedge clk);
        #1 full = 1'b0;
        @(posedge clk);
        #1 begin start = 1'b1; num_words = 16'd7; end
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("frame20");
        chk("frame20_count", got_q.size(), 20);
        chk("frame20_word0", got_q[0], 12'h000);
        chk("frame20_word19", got_q[19], 12'h098);
        chk("frame20_first_run", first_run, 24'h555000);

        // Bring next_val to 0xFF0, then a 4-word frame crosses the 12-bit wrap
        launch(490);
        wait_done("frame490");
        launch(4);
        wait_done("frame_wrap");
        chk("wrap_count", got_q.size(), 514);
        chk("wrap_w0", got_q[510], 12'hFF0);
        chk("wrap_w1", got_q[511], 12'hFF8);
        chk("wrap_w2", got_q[512], 12'h000);
        chk("wrap_w3", got_q[513], 12'h008);

        // Asynchronous reset in the middle of a payload run
        launch(30);
        wait_words(520);
        @(posedge clk);
        #3;
        chk_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("mid_reset");
        exp_q.delete();
        m_val = START;
        m_lfsr = SEED;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;

        // Restart after reset: fresh preamble and START_VAL
        base = got_q.size();
        launch(3);
        wait_done("restart");
        chk("restart_first_beat", first_beat, 24'hAAAAAA);
        chk("restart_count", got_q.size(), base + 3);
        chk("restart_word0", got_q[base], 12'h000);
        chk("restart_word2", got_q[base + 2], 12'h010);
        chk("restart_first_run", first_run, 24'h555000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
